// File: rtl/tinyqv_mem_arbiter.sv
// Shares one memory controller port between the CPU's instruction fetch and its data port.
// Fetch issues 16-bit reads from a self-incrementing pointer. Data pre-empts fetch once FETCH_MIN halfwords are done.
module tinyqv_mem_arbiter #(
    parameter int FETCH_MIN = 2
) (
    input  logic        clk,
    input  logic        rstn,

    input  logic [23:1] instr_addr,
    input  logic        instr_fetch_restart,
    input  logic        instr_fetch_stall,
    input  logic        instr_fetch_flush,
    output logic        instr_fetch_started,
    output logic        instr_fetch_stopped,
    output logic [15:0] instr_data,
    output logic        instr_ready,

    input  logic [23:0] data_addr,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    input  logic [31:0] data_wdata,
    output logic        data_ready,
    output logic [31:0] data_rdata,

    output logic [23:0] mem_addr,
    output logic [1:0]  mem_write_n,
    output logic [1:0]  mem_read_n,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, FETCH, DATA, GAP} state_t;

    state_t      state_q, state_d;
    logic        gap_to_data_q, gap_to_data_d;
    logic [23:0] fetch_ptr_q, fetch_ptr_d;
    logic [3:0]  count_q, count_d;
    logic        discard_q, discard_d;
    logic [23:0] mem_addr_q, mem_addr_d;
    logic [1:0]  mem_read_n_q, mem_read_n_d;
    logic [1:0]  mem_write_n_q, mem_write_n_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        started_q, started_d;
    logic        stopped_q, stopped_d;

    logic data_pending;
    logic quota_met;

    assign data_pending = (data_read_n != 2'b11) || (data_write_n != 2'b11);
    // count_q is the number already completed, so +1 includes the one finishing now
    assign quota_met    = ({1'b0, count_q} + 5'd1) >= 5'(FETCH_MIN);

    always_comb begin
        state_d       = state_q;
        gap_to_data_d = gap_to_data_q;
        fetch_ptr_d   = fetch_ptr_q;
        count_d       = count_q;
        discard_d     = discard_q;
        mem_addr_d    = mem_addr_q;
        mem_read_n_d  = mem_read_n_q;
        mem_write_n_d = mem_write_n_q;
        mem_wdata_d   = mem_wdata_q;
        started_d     = 1'b0;
        stopped_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (data_pending) begin
                    state_d       = DATA;
                    mem_addr_d    = data_addr;
                    mem_read_n_d  = data_read_n;
                    mem_write_n_d = data_write_n;
                    mem_wdata_d   = data_wdata;
                end else if (instr_fetch_restart && !instr_fetch_stall) begin
                    state_d      = FETCH;
                    fetch_ptr_d  = {instr_addr, 1'b0};
                    mem_addr_d   = {instr_addr, 1'b0};
                    mem_read_n_d = 2'b01;
                    count_d      = 4'd0;
                    discard_d    = 1'b0;
                    started_d    = 1'b1;
                end
            end

            FETCH: begin
                if (instr_fetch_flush) begin
                    discard_d = 1'b1;
                end
                if (mem_ready) begin
                    mem_read_n_d = 2'b11;
                    fetch_ptr_d  = fetch_ptr_q + 24'd2;
                    count_d      = (count_q == 4'd15) ? count_q : count_q + 4'd1;
                    if (discard_q || instr_fetch_flush) begin
                        state_d   = IDLE;
                        stopped_d = 1'b1;
                        discard_d = 1'b0;
                    end else if (data_pending && quota_met) begin
                        state_d       = GAP;
                        gap_to_data_d = 1'b1;
                        stopped_d     = 1'b1;
                    end else if (instr_fetch_stall) begin
                        state_d   = IDLE;
                        stopped_d = 1'b1;
                    end else begin
                        state_d       = GAP;
                        gap_to_data_d = 1'b0;
                    end
                end
            end

            GAP: begin
                if (gap_to_data_q) begin
                    if (data_pending) begin
                        state_d       = DATA;
                        mem_addr_d    = data_addr;
                        mem_read_n_d  = data_read_n;
                        mem_write_n_d = data_write_n;
                        mem_wdata_d   = data_wdata;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (instr_fetch_flush) begin
                    // Fetch is still considered active here, so abandoning it must report stopped
                    state_d   = IDLE;
                    stopped_d = 1'b1;
                end else begin
                    state_d      = FETCH;
                    mem_addr_d   = fetch_ptr_q;
                    mem_read_n_d = 2'b01;
                end
            end

            DATA: begin
                if (mem_ready) begin
                    state_d       = IDLE;
                    mem_read_n_d  = 2'b11;
                    mem_write_n_d = 2'b11;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= IDLE;
            gap_to_data_q <= 1'b0;
            fetch_ptr_q   <= 24'd0;
            count_q       <= 4'd0;
            discard_q     <= 1'b0;
            mem_addr_q    <= 24'd0;
            mem_read_n_q  <= 2'b11;
            mem_write_n_q <= 2'b11;
            mem_wdata_q   <= 32'd0;
            started_q     <= 1'b0;
            stopped_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            gap_to_data_q <= gap_to_data_d;
            fetch_ptr_q   <= fetch_ptr_d;
            count_q       <= count_d;
            discard_q     <= discard_d;
            mem_addr_q    <= mem_addr_d;
            mem_read_n_q  <= mem_read_n_d;
            mem_write_n_q <= mem_write_n_d;
            mem_wdata_q   <= mem_wdata_d;
            started_q     <= started_d;
            stopped_q     <= stopped_d;
        end
    end

    assign mem_addr            = mem_addr_q;
    assign mem_read_n          = mem_read_n_q;
    assign mem_write_n         = mem_write_n_q;
    assign mem_wdata           = mem_wdata_q;
    assign instr_fetch_started = started_q;
    assign instr_fetch_stopped = stopped_q;

    assign instr_ready = (state_q == FETCH) && mem_ready && !discard_q;
    assign instr_data  = mem_rdata[15:0];
    assign data_ready  = (state_q == DATA) && mem_ready;
    assign data_rdata  = mem_rdata;

endmodule

// File: tb/tb_tinyqv_mem_arbiter.sv
// Directed bench for tinyqv_mem_arbiter with a fixed-latency memory responder.
// Read data returned is {16'hC0DE, mem_addr[15:0] ^ 16'h1234}.
module tb_tinyqv_mem_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic [23:1] instr_addr;
    logic        instr_fetch_restart, instr_fetch_stall, instr_fetch_flush;
    logic        instr_fetch_started, instr_fetch_stopped;
    logic [15:0] instr_data;
    logic        instr_ready;
    logic [23:0] data_addr;
    logic [1:0]  data_write_n, data_read_n;
    logic [31:0] data_wdata;
    logic        data_ready;
    logic [31:0] data_rdata;
    logic [23:0] mem_addr;
    logic [1:0]  mem_write_n, mem_read_n;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int assert_count = 0;
    int fail_count = 0;
    int data_ready_count = 0;
    int resp_cnt = 0;

    tinyqv_mem_arbiter #(.FETCH_MIN(2)) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .instr_addr          (instr_addr),
        .instr_fetch_restart (instr_fetch_restart),
        .instr_fetch_stall   (instr_fetch_stall),
        .instr_fetch_flush   (instr_fetch_flush),
        .instr_fetch_started (instr_fetch_started),
        .instr_fetch_stopped (instr_fetch_stopped),
        .instr_data          (instr_data),
        .instr_ready         (instr_ready),
        .data_addr           (data_addr),
        .data_write_n        (data_write_n),
        .data_read_n         (data_read_n),
        .data_wdata          (data_wdata),
        .data_ready          (data_ready),
        .data_rdata          (data_rdata),
        .mem_addr            (mem_addr),
        .mem_write_n         (mem_write_n),
        .mem_read_n          (mem_read_n),
        .mem_wdata           (mem_wdata),
        .mem_ready           (mem_ready),
        .mem_rdata           (mem_rdata)
    );

    initial forever #5 clk = ~clk;

    // Memory model: mem_ready rises in the third cycle a request is visible, for one cycle
    initial begin
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                mem_ready = 1'b0;
                resp_cnt  = 0;
            end else if (mem_ready) begin
                mem_ready = 1'b0;
                resp_cnt  = 0;
            end else if (mem_read_n != 2'b11 || mem_write_n != 2'b11) begin
                resp_cnt = resp_cnt + 1;
                if (resp_cnt == 3) begin
                    mem_ready = 1'b1;
                    mem_rdata = {16'hC0DE, mem_addr[15:0] ^ 16'h1234};
                end
            end else begin
                resp_cnt = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one cycle and sample well after the responder has updated
    task automatic tick();
        @(negedge clk);
        #2;
        if (data_ready === 1'b1) data_ready_count++;
        if (instr_fetch_started === 1'b1 && instr_fetch_stopped === 1'b1)
            check_output("started_stopped_exclusive", 32'd1, 32'd0);
    endtask

    task automatic wait_mem_ready(input string tag);
        for (int i = 0; i < 20 && mem_ready !== 1'b1; i++) tick();
        check_output(tag, {31'd0, mem_ready}, 32'd1);
    endtask

    task automatic apply_stimulus_restart(input logic [23:1] addr);
        instr_addr          = addr;
        instr_fetch_restart = 1'b1;
        tick();
        instr_fetch_restart = 1'b0;
    endtask

    initial begin
        rstn                = 1'b0;
        instr_addr          = '0;
        instr_fetch_restart = 1'b0;
        instr_fetch_stall   = 1'b0;
        instr_fetch_flush   = 1'b0;
        data_addr           = '0;
        data_write_n        = 2'b11;
        data_read_n         = 2'b11;
        data_wdata          = '0;
        tick();
        tick();
        check_output("rst_read_n", {30'd0, mem_read_n}, 32'h3);
        check_output("rst_write_n", {30'd0, mem_write_n}, 32'h3);
        check_output("rst_started", {31'd0, instr_fetch_started}, 32'd0);
        check_output("rst_stopped", {31'd0, instr_fetch_stopped}, 32'd0);
        check_output("rst_instr_ready", {31'd0, instr_ready}, 32'd0);
        check_output("rst_data_ready", {31'd0, data_ready}, 32'd0);
        rstn = 1'b1;
        tick();

        $display("[TB] basic fetch from 0x000100");
        apply_stimulus_restart(23'h000100);
        check_output("t1_started", {31'd0, instr_fetch_started}, 32'd1);
        check_output("t1_read_n", {30'd0, mem_read_n}, 32'h1);
        check_output("t1_addr0", {8'd0, mem_addr}, 32'h000200);
        tick();
        check_output("t1_started_pulse", {31'd0, instr_fetch_started}, 32'd0);
        wait_mem_ready("t1_ready0");
        check_output("t1_iready0", {31'd0, instr_ready}, 32'd1);
        check_output("t1_idata0", {16'd0, instr_data}, 32'h1034);
        tick();
        check_output("t1_gap_read_n", {30'd0, mem_read_n}, 32'h3);
        check_output("t1_gap_iready", {31'd0, instr_ready}, 32'd0);
        check_output("t1_gap_stopped", {31'd0, instr_fetch_stopped}, 32'd0);
        tick();
        check_output("t1_addr1", {8'd0, mem_addr}, 32'h000202);
        check_output("t1_read_n1", {30'd0, mem_read_n}, 32'h1);
        check_output("t1_no_restart_pulse", {31'd0, instr_fetch_started}, 32'd0);

        $display("[TB] stall during second halfword");
        instr_fetch_stall = 1'b1;
        wait_mem_ready("t2_ready1");
        check_output("t2_iready1", {31'd0, instr_ready}, 32'd1);
        check_output("t2_idata1", {16'd0, instr_data}, 32'h1036);
        tick();
        check_output("t2_stopped", {31'd0, instr_fetch_stopped}, 32'd1);
        check_output("t2_read_n", {30'd0, mem_read_n}, 32'h3);
        tick();
        tick();
        tick();
        check_output("t2_stopped_pulse", {31'd0, instr_fetch_stopped}, 32'd0);
        check_output("t2_idle_read_n", {30'd0, mem_read_n}, 32'h3);
        instr_fetch_stall = 1'b0;

        $display("[TB] data load pre-empts after quota");
        apply_stimulus_restart(23'h000300);
        check_output("t3_addr0", {8'd0, mem_addr}, 32'h000600);
        data_read_n = 2'b10;
        data_addr   = 24'h000040;
        wait_mem_ready("t3_ready0");
        check_output("t3_idata0", {16'd0, instr_data}, 32'h1434);
        tick();
        check_output("t3_gap_stopped", {31'd0, instr_fetch_stopped}, 32'd0);
        tick();
        check_output("t3_addr1", {8'd0, mem_addr}, 32'h000602);
        check_output("t3_read_n1", {30'd0, mem_read_n}, 32'h1);
        wait_mem_ready("t3_ready1");
        check_output("t3_iready1", {31'd0, instr_ready}, 32'd1);
        check_output("t3_idata1", {16'd0, instr_data}, 32'h1436);
        tick();
        check_output("t3_stopped", {31'd0, instr_fetch_stopped}, 32'd1);
        check_output("t3_gap_read_n", {30'd0, mem_read_n}, 32'h3);
        tick();
        check_output("t3_data_read_n", {30'd0, mem_read_n}, 32'h2);
        check_output("t3_data_addr", {8'd0, mem_addr}, 32'h000040);
        wait_mem_ready("t3_data_ready_wait");
        check_output("t3_data_ready", {31'd0, data_ready}, 32'd1);
        check_output("t3_data_rdata", data_rdata, 32'hC0DE1274);
        check_output("t3_no_iready", {31'd0, instr_ready}, 32'd0);
        data_read_n = 2'b11;
        tick();
        check_output("t3_idle_read_n", {30'd0, mem_read_n}, 32'h3);
        check_output("t3_idle_dready", {31'd0, data_ready}, 32'd0);

        $display("[TB] flush mid-fetch");
        apply_stimulus_restart(23'h000500);
        check_output("t4_addr0", {8'd0, mem_addr}, 32'h000A00);
        tick();
        instr_fetch_flush = 1'b1;
        tick();
        instr_fetch_flush = 1'b0;
        wait_mem_ready("t4_ready0");
        check_output("t4_discarded", {31'd0, instr_ready}, 32'd0);
        tick();
        check_output("t4_stopped", {31'd0, instr_fetch_stopped}, 32'd1);
        check_output("t4_read_n", {30'd0, mem_read_n}, 32'h3);
        tick();
        check_output("t4_still_idle", {30'd0, mem_read_n}, 32'h3);
        apply_stimulus_restart(23'h000800);
        check_output("t4_restarted", {31'd0, instr_fetch_started}, 32'd1);
        check_output("t4_addr1", {8'd0, mem_addr}, 32'h001000);
        instr_fetch_stall = 1'b1;
        wait_mem_ready("t4_ready1");
        check_output("t4_iready1", {31'd0, instr_ready}, 32'd1);
        check_output("t4_idata1", {16'd0, instr_data}, 32'h0234);
        tick();
        check_output("t4_stopped1", {31'd0, instr_fetch_stopped}, 32'd1);
        instr_fetch_stall = 1'b0;

        $display("[TB] store and restart together");
        data_ready_count    = 0;
        data_write_n        = 2'b01;
        data_addr           = 24'h123456;
        data_wdata          = 32'hDEADBEEF;
        instr_addr          = 23'h000010;
        instr_fetch_restart = 1'b1;
        tick();
        check_output("t5_write_n", {30'd0, mem_write_n}, 32'h1);
        check_output("t5_read_n", {30'd0, mem_read_n}, 32'h3);
        check_output("t5_addr", {8'd0, mem_addr}, 32'h123456);
        check_output("t5_wdata", mem_wdata, 32'hDEADBEEF);
        check_output("t5_no_started", {31'd0, instr_fetch_started}, 32'd0);
        wait_mem_ready("t5_ready");
        check_output("t5_data_ready", {31'd0, data_ready}, 32'd1);
        data_write_n = 2'b11;
        tick();
        check_output("t5_gap_read_n", {30'd0, mem_read_n}, 32'h3);
        check_output("t5_gap_write_n", {30'd0, mem_write_n}, 32'h3);
        check_output("t5_gap_started", {31'd0, instr_fetch_started}, 32'd0);
        tick();
        instr_fetch_restart = 1'b0;
        check_output("t5_started", {31'd0, instr_fetch_started}, 32'd1);
        check_output("t5_fetch_addr", {8'd0, mem_addr}, 32'h000020);
        check_output("t5_fetch_read_n", {30'd0, mem_read_n}, 32'h1);
        instr_fetch_stall = 1'b1;
        wait_mem_ready("t5_fetch_ready");
        tick();
        check_output("t5_stopped", {31'd0, instr_fetch_stopped}, 32'd1);
        check_output("t5_data_ready_once", data_ready_count, 32'd1);
        instr_fetch_stall = 1'b0;

        $display("[TB] address wrap and reset mid-read");
        apply_stimulus_restart(23'h7FFFFF);
        check_output("t6_addr0", {8'd0, mem_addr}, 32'hFFFFFE);
        wait_mem_ready("t6_ready0");
        check_output("t6_idata0", {16'd0, instr_data}, 32'hEDCA);
        tick();
        tick();
        check_output("t6_wrap_addr", {8'd0, mem_addr}, 32'h000000);
        check_output("t6_wrap_read_n", {30'd0, mem_read_n}, 32'h1);
        rstn = 1'b0;
        tick();
        check_output("t6_rst_read_n", {30'd0, mem_read_n}, 32'h3);
        check_output("t6_rst_started", {31'd0, instr_fetch_started}, 32'd0);
        check_output("t6_rst_stopped", {31'd0, instr_fetch_stopped}, 32'd0);
        check_output("t6_rst_iready", {31'd0, instr_ready}, 32'd0);
        check_output("t6_rst_dready", {31'd0, data_ready}, 32'd0);
        rstn = 1'b1;
        tick();
        tick();
        check_output("t6_post_rst_read_n", {30'd0, mem_read_n}, 32'h3);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
